regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the core's decode/writeback stages; successor to the single-write, two-read register file. It adds configurable width, depth and read/write port counts, deterministic write-port priority, a per-register busy scoreboard for pipeline interlock, and a post-reset hardware clear sequence that zeroes storage before the core is released.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses, port p at bits [p*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, packed the same way
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  read-port operand still pending (scoreboard)
- sb_set  in  1  mark sb_addr busy (instruction issued with destination)
- sb_addr  in  ADDR_W  destination being marked busy
- init_done  out  1  clear sequence complete; core must not issue before high

## Operation
- FSM states: CLEAR, RUN. rst forces CLEAR, clear counter cnt=0, all busy bits 0.
- CLEAR: each cycle writes 0 to regs[cnt], cnt++; on cnt==DEPTH-1, next state RUN. Port writes and sb_set ignored. init_done=0, rdata=0, rd_busy=0.
- RUN: init_done=1 (registered).
- Write: port p with we[p]=1 and waddr!=0 updates regs[waddr] at edge. Address 0 writes discarded; register 0 always reads 0.
- Same-address conflict: highest-index enabled port wins, for storage and bypass.
- Read port i: re[i]=0 -> 0; raddr==0 -> 0; raddr matches an enabled nonzero write this cycle -> winning wdata (bypass); else regs[raddr].
- Scoreboard: busy[a] set by sb_set at edge (a!=0); cleared by any enabled write to a. Set and clear of same address in one cycle: set wins (new producer). busy[0] constant 0.
- rd_busy[i] = re[i] & busy[raddr[i]] & ~(raddr[i] written this cycle); 0 when raddr==0.

## Timing
- Reset values: init_done=0, rd_busy=0, rdata=0, all busy bits 0; storage contents undefined until clear completes.
- Clear latency: rst deasserted before edge 0; init_done high after edge DEPTH (DEPTH cycles, 32 for default).
- rst asserted mid-CLEAR or mid-RUN: restart at CLEAR, cnt=0, scoreboard cleared, in-flight writes that cycle dropped.
- Write-to-read: 0 cycles via bypass, 1 cycle via storage.
- sb_set to rd_busy: 1 cycle. Writeback clears rd_busy same cycle (combinational) and in state next edge.
- No simulation-only display statements in RTL.

## Structure
- Shared package regfile_pkg: FSM state enum (CLEAR, RUN), ZERO_WORD, NOP_REG_ADDR=0 constant, default DATA_W/ADDR_W.
- One sub-module: regfile_scoreboard (DEPTH busy bits, set/clear priority, NUM_RD lookup ports). Storage, bypass and clear FSM stay in regfile_mp.

## Test plan
- Reset release: rst high 2 cycles, low -> init_done=0 for 32 cycles, =1 at cycle 32; all 32 registers read 0.
- Basic/bypass: write x3=0xDEADBEEF port 0 while reading raddr0=3 same cycle -> rdata0=0xDEADBEEF; next cycle still 0xDEADBEEF; write to x0=0x1234 -> x0 reads 0.
- Write conflict: port0 x5=0x11, port1 x5=0x22 same cycle -> bypass and later read both 0x22.
- Scoreboard: sb_set x7 -> next cycle rd_busy0=1 for raddr0=7; write x7=0x5 -> rd_busy0=0 same cycle, rdata0=0x5; simultaneous sb_set x7 and write x7 -> busy stays 1.
- Mid-clear reset: assert rst at clear cycle 10 -> init_done stays 0, completes 32 cycles after rst deasserts; busy bits all 0.
- Re low: re1=0 with raddr1=3 holding 0xDEADBEEF -> rdata1=0, rd_busy1=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Imported by the interface, the scoreboard and the top.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NOP_REG_ADDR = 0;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file.
// master = core side, slave = register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);

    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic                     init_done;

    modport master (
        output we, waddr, wdata,
        output re, raddr,
        output sb_set, sb_addr,
        input  rdata, rd_busy, init_done
    );

    modport slave (
        input  we, waddr, wdata,
        input  re, raddr,
        input  sb_set, sb_addr,
        output rdata, rd_busy, init_done
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for operand interlock.
// A new producer (set) outranks a writeback (clear) to the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic [NUM_WR-1:0]        clr_en,
    input  logic [NUM_WR*ADDR_W-1:0] clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
    output logic [NUM_RD-1:0]        lk_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] A0 = ADDR_W'(NOP_REG_ADDR);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W-1:0] lk_a   [NUM_RD];
    logic [NUM_RD-1:0] lk_hit;

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (clr_en[p]) begin
                busy_d[clr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[NOP_REG_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A writeback landing this cycle already satisfies the operand.
    always_comb begin
        lk_busy = '0;
        lk_hit  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            lk_a[i] = lk_addr[i*ADDR_W +: ADDR_W];
            for (int p = 0; p < NUM_WR; p++) begin
                if (clr_en[p] &&
                    clr_addr[p*ADDR_W +: ADDR_W] == lk_a[i]) begin
                    lk_hit[i] = 1'b1;
                end
            end
            lk_busy[i] = busy_q[lk_a[i]] & ~lk_hit[i] &
                         (lk_a[i] != A0);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: storage, write bypass and
// the post-reset clear sequence; busy tracking lives in the scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] A0    = ADDR_W'(NOP_REG_ADDR);
    localparam logic [ADDR_W-1:0] A_TOP = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZW    = DATA_W'(ZERO_WORD);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              init_done_q;
    logic              init_done_d;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic              active;
    logic [NUM_WR-1:0] wr_en;
    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [DATA_W-1:0] wr_data [NUM_WR];

    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [NUM_RD-1:0] byp_hit;
    logic [DATA_W-1:0] byp_data [NUM_RD];
    logic [NUM_RD-1:0] sb_busy;

    // Writes taken in the reset cycle are dropped, so gate with rst too.
    assign active = (state_q == RUN) & ~rst;

    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_addr[p] = bus.waddr[p*ADDR_W +: ADDR_W];
            wr_data[p] = bus.wdata[p*DATA_W +: DATA_W];
            wr_en[p]   = bus.we[p] & active & (wr_addr[p] != A0);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == A_TOP) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        if (rst) begin
            state_d     = CLEAR;
            cnt_d       = '0;
            init_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        init_done_q <= init_done_d;
    end

    // Ascending port order: the highest-index writer lands last and wins.
    always_comb begin
        regs_d = regs_q;
        if (!rst && state_q == CLEAR) begin
            regs_d[cnt_q] = ZW;
        end
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                regs_d[wr_addr[p]] = wr_data[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        bus.rdata = '0;
        byp_hit   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr[i]  = bus.raddr[i*ADDR_W +: ADDR_W];
            byp_data[i] = ZW;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_addr[p] == rd_addr[i]) begin
                    byp_hit[i]  = 1'b1;
                    byp_data[i] = wr_data[p];
                end
            end
            if (active && bus.re[i] && rd_addr[i] != A0) begin
                bus.rdata[i*DATA_W +: DATA_W] =
                    byp_hit[i] ? byp_data[i] : regs_q[rd_addr[i]];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.sb_set & active),
        .set_addr (bus.sb_addr),
        .clr_en   (wr_en),
        .clr_addr (bus.waddr),
        .lk_addr  (bus.raddr),
        .lk_busy  (sb_busy)
    );

    assign bus.rd_busy   = sb_busy & bus.re & {NUM_RD{active}};
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence, bypass, port
// priority, scoreboard interlock and reset during clear.
module tb_regfile_mp;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    regfile_mp_if #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .NUM_WR (2)
    ) bus ();

    regfile_mp #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst         = 1'b1;
        bus.we      = '0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.re      = '0;
        bus.raddr   = '0;
        bus.sb_set  = 1'b0;
        bus.sb_addr = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_rd_busy", 32'(bus.rd_busy), 32'd0);
        chk("rst_rdata", bus.rdata[31:0], 32'd0);

        // clear sequence; port writes and sb_set must be ignored
        rst         = 1'b0;
        bus.we      = 2'b01;
        bus.waddr   = {5'd0, 5'd9};
        bus.wdata   = {32'h0, 32'hCAFE0009};
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd9;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("clr_init_done_%0d", i),
                32'(bus.init_done), (i == 31) ? 32'd1 : 32'd0);
        end
        bus.we     = '0;
        bus.sb_set = 1'b0;

        // every register reads zero after clear
        @(negedge clk);
        bus.re = 2'b01;
        for (int a = 0; a < 32; a++) begin
            bus.raddr = {5'd0, 5'(a)};
            #1;
            chk($sformatf("clr_rd_x%0d", a), bus.rdata[31:0], 32'd0);
        end
        bus.raddr = {5'd0, 5'd9};
        #1;
        chk("clr_sb_ignored", 32'(bus.rd_busy[0]), 32'd0);

        // write + same-cycle bypass, then storage
        @(negedge clk);
        bus.we    = 2'b01;
        bus.waddr = {5'd0, 5'd3};
        bus.wdata = {32'h0, 32'hDEADBEEF};
        bus.raddr = {5'd0, 5'd3};
        #1;
        chk("byp_x3", bus.rdata[31:0], 32'hDEADBEEF);
        @(negedge clk);
        bus.we = '0;
        #1;
        chk("sto_x3", bus.rdata[31:0], 32'hDEADBEEF);

        // x0 is hardwired
        @(negedge clk);
        bus.we    = 2'b01;
        bus.waddr = {5'd0, 5'd0};
        bus.wdata = {32'h0, 32'h00001234};
        bus.raddr = {5'd0, 5'd0};
        #1;
        chk("byp_x0", bus.rdata[31:0], 32'd0);
        @(negedge clk);
        bus.we = '0;
        #1;
        chk("sto_x0", bus.rdata[31:0], 32'd0);

        // same-address conflict: port 1 wins
        @(negedge clk);
        bus.we    = 2'b11;
        bus.waddr = {5'd5, 5'd5};
        bus.wdata = {32'h22, 32'h11};
        bus.re    = 2'b11;
        bus.raddr = {5'd5, 5'd5};
        #1;
        chk("cfl_byp_p0", bus.rdata[31:0], 32'h22);
        chk("cfl_byp_p1", bus.rdata[63:32], 32'h22);
        @(negedge clk);
        bus.we = '0;
        #1;
        chk("cfl_sto_p0", bus.rdata[31:0], 32'h22);
        chk("cfl_sto_p1", bus.rdata[63:32], 32'h22);

        // scoreboard: set, writeback clear, set beats clear
        @(negedge clk);
        bus.re      = 2'b01;
        bus.raddr   = {5'd0, 5'd7};
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd7;
        #1;
        chk("sb_pre_set", 32'(bus.rd_busy[0]), 32'd0);
        @(negedge clk);
        bus.sb_set = 1'b0;
        #1;
        chk("sb_busy_x7", 32'(bus.rd_busy[0]), 32'd1);
        @(negedge clk);
        bus.we    = 2'b01;
        bus.waddr = {5'd0, 5'd7};
        bus.wdata = {32'h0, 32'h5};
        #1;
        chk("sb_wb_busy", 32'(bus.rd_busy[0]), 32'd0);
        chk("sb_wb_data", bus.rdata[31:0], 32'h5);
        @(negedge clk);
        bus.we = '0;
        #1;
        chk("sb_cleared", 32'(bus.rd_busy[0]), 32'd0);
        chk("sb_sto_data", bus.rdata[31:0], 32'h5);
        @(negedge clk);
        bus.we      = 2'b01;
        bus.wdata   = {32'h0, 32'h6};
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd7;
        #1;
        chk("sb_both_busy", 32'(bus.rd_busy[0]), 32'd0);
        @(negedge clk);
        bus.we     = '0;
        bus.sb_set = 1'b0;
        #1;
        chk("sb_set_wins", 32'(bus.rd_busy[0]), 32'd1);
        chk("sb_set_data", bus.rdata[31:0], 32'h6);

        // re low masks data and busy on port 1
        @(negedge clk);
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd3;
        @(negedge clk);
        bus.sb_set = 1'b0;
        bus.re     = 2'b10;
        bus.raddr  = {5'd3, 5'd0};
        #1;
        chk("re1_data", bus.rdata[63:32], 32'hDEADBEEF);
        chk("re1_busy", 32'(bus.rd_busy[1]), 32'd1);
        bus.re = 2'b00;
        #1;
        chk("re0_data", bus.rdata[63:32], 32'd0);
        chk("re0_busy", 32'(bus.rd_busy[1]), 32'd0);

        // reset from RUN, then again at clear cycle 10
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("run_rst_done", 32'(bus.init_done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mid_pre_%0d", i), 32'(bus.init_done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_done", 32'(bus.init_done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mid_clr_%0d", i),
                32'(bus.init_done), (i == 31) ? 32'd1 : 32'd0);
        end

        // scoreboard and storage cleared again
        @(negedge clk);
        bus.re = 2'b11;
        for (int a = 1; a < 32; a++) begin
            bus.raddr = {5'(a), 5'(a)};
            #1;
            chk($sformatf("mid_busy_x%0d", a), 32'(bus.rd_busy), 32'd0);
            chk($sformatf("mid_data_x%0d", a), bus.rdata[63:32], 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
